pipelined_memory: RTL and testbench
===================================

# pipelined_memory

Parametrised successor to the design's main memory: single-clock, word-addressed RAM with byte-strobed writes, a fixed-latency pipelined read port with valid tagging, and a post-reset zero-fill sequencer. It sits between the CPU datapath (fetch/load-store) and storage. It replaces the combinational-read model with one that maps onto synchronous block RAM.

## Interface
- DATA_WIDTH, 32, word width in bits; multiple of 8
- DEPTH, 2048, number of words; power of two, ≥ 2
- ADDR_WIDTH, 32, width of the address ports; ≥ log2(DEPTH)
- READ_LATENCY, 1, cycles from accepted read to rd_valid; legal 1..4

- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- ready  output  1  high when requests are accepted (RUN state)
- rd_req  input  1  read request, accepted when ready
- rd_addr  input  ADDR_WIDTH  read word address
- rd_data  output  DATA_WIDTH  read data, meaningful when rd_valid
- rd_valid  output  1  read result valid pulse
- rd_err  output  1  out-of-range flag, qualified by rd_valid
- wr_en  input  1  write request, accepted when ready
- wr_addr  input  ADDR_WIDTH  write word address
- wr_data  input  DATA_WIDTH  write data
- wr_strb  input  DATA_WIDTH/8  byte enables; bit i covers wr_data[8i+7:8i]
- wr_err  output  1  registered out-of-range flag for the previous cycle's accepted write

## Operation
- FSM states: INIT, RUN.
- rst → INIT; init counter ← 0; all pipeline valid bits cleared.
- INIT: write 0 to mem[counter] each cycle; counter increments; after writing DEPTH−1 → RUN. ready = 0. rd_req/wr_en ignored (no data, no valid, no error).
- RUN: ready = 1; stays until rst.
- Write: in RUN, when wr_en is high, bytes with wr_strb[i] = 1 update; other bytes are retained. wr_strb = 0 means no change.
- Read: in RUN, rd_req accepted every cycle (throughput 1/cycle). Address and valid travel through a READ_LATENCY-stage pipeline; the array read is synchronous.
- Same-cycle read and write to the same address: read-first. rd_data returns the pre-write word.
- Write then read of the same address on the next cycle returns the new data.
- Memory contents are defined only by the zero-fill and writes; no other reset of the array.
- rst asserted mid-operation: in-flight reads are discarded (rd_valid = 0 from the next cycle), writes that cycle are dropped, and zero-fill restarts.

## Timing
- Reset values: ready 0, rd_valid 0, rd_err 0, wr_err 0, rd_data 0.
- Zero-fill takes exactly DEPTH cycles. ready rises on the DEPTH-th rising edge after rst deasserts. The first request is accepted that cycle.
- Read accepted on edge N → rd_valid = 1 with rd_data/rd_err in the cycle following edge N+READ_LATENCY−1. For READ_LATENCY=1, data is visible the cycle after the request.
- rd_valid is a one-cycle pulse per accepted request. Back-to-back requests give back-to-back valids in order.
- rd_data holds its last value when rd_valid = 0.
- wr_err is asserted the cycle after an accepted out-of-range write.

## Configuration
- Macro PIPELINED_MEMORY_BOUNDS_CHECK_EN.
- Defined: an address ≥ DEPTH is out of range.
  - Out-of-range write: array unchanged, wr_err = 1 next cycle.
  - Out-of-range read: rd_valid still pulses, rd_data = 0, rd_err = 1.
- Undefined: addresses are truncated to log2(DEPTH) LSBs (wrap-around). rd_err and wr_err are tied 0.

## Test plan
- Reset, DEPTH=16, READ_LATENCY=1: ready low for 16 cycles then high. Reads of addresses 0..15 all return 0x00000000 with one rd_valid each.
- Write 0xDEADBEEF to addr 5 with strb 4'b1111, then 0x000000AA with strb 4'b0001 → read addr 5 returns 0xDEADBEAA.
- READ_LATENCY=3: back-to-back reads of addrs 1, 2, 3 (preloaded 0x11, 0x22, 0x33) → rd_valid high for 3 consecutive cycles starting 3 cycles after the first request, with data in order.
- Same cycle: write 0x55 to addr 7 (old value 0x44) and read addr 7 → returns 0x44. A read of addr 7 the next cycle returns 0x55.
- Bounds, DEPTH=16:
  - With the macro: write to addr 16 → wr_err = 1 and addr 0 unchanged. Read of addr 20 → rd_data = 0, rd_err = 1.
  - Without the macro: write to addr 16 lands at addr 0.
- Assert rst with 2 reads in flight (READ_LATENCY=3) → no rd_valid follows; ready drops; zero-fill reruns and erases earlier writes.

Source files
------------

// File: rtl/pipelined_memory_if.sv
// Request/response bundle between the CPU datapath (master) and pipelined_memory (slave).
// Requests are accepted whenever ready is high; there is no per-request backpressure.
interface pipelined_memory_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    ready;
    logic                    rd_req;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    rd_valid;
    logic                    rd_err;
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [DATA_WIDTH/8-1:0] wr_strb;
    logic                    wr_err;

    modport master (
        input  ready, rd_data, rd_valid, rd_err, wr_err,
        output rd_req, rd_addr, wr_en, wr_addr, wr_data, wr_strb
    );

    modport slave (
        output ready, rd_data, rd_valid, rd_err, wr_err,
        input  rd_req, rd_addr, wr_en, wr_addr, wr_data, wr_strb
    );
endinterface

// File: rtl/pipelined_memory.sv
// Word-addressed byte-strobed RAM, READ_LATENCY-cycle read pipeline, zero-fill after reset (ready low DEPTH cycles).
// No backpressure once ready; PIPELINED_MEMORY_BOUNDS_CHECK_EN flags out-of-range addresses instead of wrapping.
module pipelined_memory #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 2048,
    parameter int ADDR_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    pipelined_memory_if.slave bus
);
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             ready;
    logic             fill_en;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == IDX_W'(DEPTH - 1)) begin
                state_d = ST_RUN;
            end
        end
    end

    always_comb begin
        ready   = 1'b0;
        fill_en = 1'b0;
        case (state_q)
            ST_INIT: fill_en = 1'b1;
            ST_RUN:  ready   = 1'b1;
            default: ;
        endcase
    end

    logic             rd_acc, wr_acc;
    logic             rd_oor, wr_oor;
    logic [IDX_W-1:0] rd_idx, wr_idx;

    assign rd_acc = ready & bus.rd_req & ~rst_i;
    assign wr_acc = ready & bus.wr_en & ~rst_i;
    assign rd_idx = bus.rd_addr[IDX_W-1:0];
    assign wr_idx = bus.wr_addr[IDX_W-1:0];

`ifdef PIPELINED_MEMORY_BOUNDS_CHECK_EN
    // Extra MSB keeps the compare correct when ADDR_WIDTH equals log2(DEPTH).
    assign rd_oor = {1'b0, bus.rd_addr} >= (ADDR_WIDTH + 1)'(DEPTH);
    assign wr_oor = {1'b0, bus.wr_addr} >= (ADDR_WIDTH + 1)'(DEPTH);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.rd_addr, bus.wr_addr};
    assign rd_oor           = 1'b0;
    assign wr_oor           = 1'b0;
`endif

    // Single write port shared by the zero-fill sequencer and CPU writes.
    logic                  mem_we;
    logic [IDX_W-1:0]      mem_widx;
    logic [DATA_WIDTH-1:0] mem_wdat;
    logic [STRB_W-1:0]     mem_wbe;

    always_comb begin
        mem_we   = 1'b0;
        mem_widx = wr_idx;
        mem_wdat = bus.wr_data;
        mem_wbe  = bus.wr_strb;
        if (fill_en) begin
            mem_we   = ~rst_i;
            mem_widx = cnt_q;
            mem_wdat = '0;
            mem_wbe  = '1;
        end else if (wr_acc && !wr_oor) begin
            mem_we = 1'b1;
        end
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (mem_wbe[b]) begin
                    mem_q[mem_widx][8*b +: 8] <= mem_wdat[8*b +: 8];
                end
            end
        end
    end

    // Stage 0 is the synchronous array read; data/err only advance with a valid so the output holds.
    logic [READ_LATENCY-1:0] vld_q;
    logic [READ_LATENCY-1:0] err_q;
    logic [DATA_WIDTH-1:0]   dat_q [READ_LATENCY];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= '0;
            err_q <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                dat_q[k] <= '0;
            end
        end else begin
            vld_q[0] <= rd_acc;
            if (rd_acc) begin
                err_q[0] <= rd_oor;
                dat_q[0] <= rd_oor ? '0 : mem_q[rd_idx];
            end
            for (int k = 1; k < READ_LATENCY; k++) begin
                vld_q[k] <= vld_q[k-1];
                if (vld_q[k-1]) begin
                    err_q[k] <= err_q[k-1];
                    dat_q[k] <= dat_q[k-1];
                end
            end
        end
    end

    logic wr_err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_acc & wr_oor;
        end
    end

    assign bus.ready    = ready;
    assign bus.rd_valid = vld_q[READ_LATENCY-1];
    assign bus.rd_data  = dat_q[READ_LATENCY-1];
    assign bus.rd_err   = err_q[READ_LATENCY-1];
    assign bus.wr_err   = wr_err_q;

endmodule

// File: tb/tb_pipelined_memory.sv
// Drives two pipelined_memory instances (READ_LATENCY 1 and 3) with identical stimulus
// and compares both against a queue/array reference model.
module tb_pipelined_memory;
    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int DEPTH = 16;
    localparam int SW    = DW / 8;
`ifdef PIPELINED_MEMORY_BOUNDS_CHECK_EN
    localparam bit BCHK = 1'b1;
`else
    localparam bit BCHK = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [SW-1:0] wr_strb;

    pipelined_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_a ();
    pipelined_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_b ();

    assign bus_a.rd_req  = rd_req;
    assign bus_a.rd_addr = rd_addr;
    assign bus_a.wr_en   = wr_en;
    assign bus_a.wr_addr = wr_addr;
    assign bus_a.wr_data = wr_data;
    assign bus_a.wr_strb = wr_strb;
    assign bus_b.rd_req  = rd_req;
    assign bus_b.rd_addr = rd_addr;
    assign bus_b.wr_en   = wr_en;
    assign bus_b.wr_addr = wr_addr;
    assign bus_b.wr_data = wr_data;
    assign bus_b.wr_strb = wr_strb;

    pipelined_memory #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .READ_LATENCY(1)) dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_a.slave)
    );

    pipelined_memory #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .READ_LATENCY(3)) dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_b.slave)
    );

    typedef struct {
        int          due;
        logic [DW-1:0] dat;
        logic        err;
    } exp_t;

    logic [DW-1:0] mmem [DEPTH];
    exp_t          qa[$];
    exp_t          qb[$];
    int            fill;
    int            cyc;
    logic          exp_wr_err;
    logic [DW-1:0] last_a, last_b;
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rd_req  = 1'b0;
        rd_addr = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        wr_strb = '0;
    endtask

    task automatic set_rd(input int a);
        rd_req  = 1'b1;
        rd_addr = AW'(a);
    endtask

    task automatic set_wr(input int a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        wr_strb = s;
    endtask

    task automatic rand_stim();
        rd_req  = 1'($urandom_range(0, 1));
        rd_addr = AW'($urandom_range(0, 23));
        wr_en   = 1'($urandom_range(0, 1));
        wr_addr = AW'($urandom_range(0, 23));
        wr_data = $urandom;
        wr_strb = SW'($urandom);
    endtask

    // Advance one clock: update the model with the inputs sampled at this edge, then check both DUTs.
    task automatic cycle();
        exp_t e;
        bit   oor;
        bit   exp_v;
        bit   was_rst;
        int   idx;
        was_rst = rst;
        if (rst) begin
            fill = 0;
            qa.delete();
            qb.delete();
            for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
            exp_wr_err = 1'b0;
            last_a = '0;
            last_b = '0;
        end else begin
            exp_wr_err = 1'b0;
            if (fill >= DEPTH) begin
                if (rd_req) begin
                    oor   = BCHK && (int'(rd_addr) >= DEPTH);
                    idx   = int'(rd_addr) % DEPTH;
                    e.dat = oor ? '0 : mmem[idx];
                    e.err = oor;
                    e.due = cyc + 1;
                    qa.push_back(e);
                    e.due = cyc + 3;
                    qb.push_back(e);
                end
                if (wr_en) begin
                    oor = BCHK && (int'(wr_addr) >= DEPTH);
                    idx = int'(wr_addr) % DEPTH;
                    if (oor) exp_wr_err = 1'b1;
                    else begin
                        for (int b = 0; b < SW; b++)
                            if (wr_strb[b]) mmem[idx][8*b +: 8] = wr_data[8*b +: 8];
                    end
                end
            end
            if (fill < DEPTH) fill++;
        end

        @(posedge clk);
        cyc++;
        #1;

        exp_v = 1'b0;
        if (qa.size() > 0) exp_v = (qa[0].due == cyc);
        if (exp_v) begin
            e = qa.pop_front();
            last_a = e.dat;
        end
        chk("a_rd_valid", {31'b0, bus_a.rd_valid}, {31'b0, exp_v});
        chk("a_rd_data", bus_a.rd_data, last_a);
        if (exp_v) chk("a_rd_err", {31'b0, bus_a.rd_err}, {31'b0, e.err});
        if (was_rst) chk("a_rd_err_rst", {31'b0, bus_a.rd_err}, '0);
        chk("a_wr_err", {31'b0, bus_a.wr_err}, {31'b0, exp_wr_err});
        chk("a_ready", {31'b0, bus_a.ready}, {31'b0, (fill >= DEPTH)});

        exp_v = 1'b0;
        if (qb.size() > 0) exp_v = (qb[0].due == cyc);
        if (exp_v) begin
            e = qb.pop_front();
            last_b = e.dat;
        end
        chk("b_rd_valid", {31'b0, bus_b.rd_valid}, {31'b0, exp_v});
        chk("b_rd_data", bus_b.rd_data, last_b);
        if (exp_v) chk("b_rd_err", {31'b0, bus_b.rd_err}, {31'b0, e.err});
        if (was_rst) chk("b_rd_err_rst", {31'b0, bus_b.rd_err}, '0);
        chk("b_wr_err", {31'b0, bus_b.wr_err}, {31'b0, exp_wr_err});
        chk("b_ready", {31'b0, bus_b.ready}, {31'b0, (fill >= DEPTH)});
    endtask

    initial begin
        cyc        = 0;
        fill       = 0;
        exp_wr_err = 1'b0;
        last_a     = '0;
        last_b     = '0;
        idle();

        // Reset, then zero-fill with requests that must be ignored.
        rst = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            rand_stim();
            cycle();
        end
        idle();

        for (int i = 0; i < DEPTH; i++) begin
            set_rd(i);
            cycle();
        end
        idle();
        repeat (4) cycle();

        // Byte-strobe merge.
        set_wr(5, 32'hDEADBEEF, 4'b1111);
        cycle();
        set_wr(5, 32'h000000AA, 4'b0001);
        cycle();
        idle();
        set_rd(5);
        cycle();
        chk("a_strb_merge", bus_a.rd_data, 32'hDEADBEAA);
        idle();
        repeat (3) cycle();

        // Back-to-back reads through the 3-stage pipeline.
        set_wr(1, 32'h11, 4'hF); cycle();
        set_wr(2, 32'h22, 4'hF); cycle();
        set_wr(3, 32'h33, 4'hF); cycle();
        idle();
        set_rd(1); cycle();
        set_rd(2); cycle();
        set_rd(3); cycle();
        idle();
        repeat (4) cycle();

        // Read-first collision, then write-then-read.
        set_wr(7, 32'h44, 4'hF);
        cycle();
        set_wr(7, 32'h55, 4'hF);
        set_rd(7);
        cycle();
        chk("a_read_first", bus_a.rd_data, 32'h44);
        idle();
        set_rd(7);
        cycle();
        chk("a_write_then_read", bus_a.rd_data, 32'h55);
        idle();
        repeat (4) cycle();

        // Boundary addresses.
        set_wr(0, 32'hCAFE, 4'hF);
        cycle();
        set_wr(16, 32'h99, 4'hF);
        cycle();
        chk("a_wr_err_addr16", {31'b0, bus_a.wr_err}, {31'b0, BCHK});
        idle();
        set_rd(0);
        cycle();
        chk("a_addr0_after_16", bus_a.rd_data, BCHK ? 32'hCAFE : 32'h99);
        set_rd(20);
        cycle();
        idle();
        repeat (4) cycle();

        for (int i = 0; i < 300; i++) begin
            rand_stim();
            cycle();
        end
        idle();
        repeat (4) cycle();

        // Reset with reads in flight; zero-fill must erase earlier writes.
        set_wr(9, 32'h12345678, 4'hF);
        cycle();
        idle();
        set_rd(9); cycle();
        set_rd(9); cycle();
        idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            rand_stim();
            cycle();
        end
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            set_rd(i);
            cycle();
        end
        idle();
        repeat (5) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
